// File: rtl/uart_word_sender.sv
// Streams a block of 16-bit memory words to a byte-wide UART transmitter,
// upper byte first, optionally followed by the program-loader terminator word.
module uart_word_sender #(
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] TERM_WORD = 16'h7fff
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [15:0]       word_count,
    input  logic              send_term,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rd_mem,
    input  logic [15:0]       rd_data,
    output logic [7:0]        tx_data,
    output logic              wr,
    input  logic              tx_ready,
    output logic              hazard
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_CAP, S_HI, S_GAP_HI, S_LO, S_GAP_LO,
        S_TERM_HI, S_TERM_GAP_HI, S_TERM_LO, S_TERM_GAP_LO, S_FIN
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       remaining_r;
    logic              term_en_r;
    logic [15:0]       word_r;
    logic              pend_r;
    logic [7:0]        hi_byte_s;

    // Memory data arrives one cycle after the strobe, i.e. on the first HI
    // cycle, so that cycle takes the byte straight from rd_data.
    always_comb begin
        hi_byte_s = word_r[15:8];
        if (pend_r) begin
            hi_byte_s = rd_data[15:8];
        end else begin
            hi_byte_s = word_r[15:8];
        end
    end

    // Transfer sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            addr_r      <= '0;
            remaining_r <= 16'd0;
            term_en_r   <= 1'b0;
            word_r      <= 16'd0;
            pend_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_addr    <= '0;
            rd_mem      <= 1'b0;
            tx_data     <= 8'd0;
            wr          <= 1'b0;
            hazard      <= 1'b0;
        end else begin
            rd_mem <= 1'b0;
            wr     <= 1'b0;
            done   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        addr_r      <= {start_addr[ADDR_W-1:1], 1'b0};
                        remaining_r <= word_count;
                        term_en_r   <= send_term;
                        hazard      <= 1'b0;
                        busy        <= 1'b1;
                        if (word_count != 16'd0) begin
                            state_r <= S_RD;
                        end else if (send_term) begin
                            state_r <= S_TERM_HI;
                        end else begin
                            state_r <= S_FIN;
                        end
                    end
                end
                S_RD: begin
                    mem_addr <= addr_r;
                    rd_mem   <= 1'b1;
                    state_r  <= S_CAP;
                end
                S_CAP: begin
                    pend_r  <= 1'b1;
                    state_r <= S_HI;
                end
                S_HI: begin
                    if (pend_r) begin
                        word_r <= rd_data;
                        pend_r <= 1'b0;
                    end
                    if (tx_ready) begin
                        tx_data <= hi_byte_s;
                        wr      <= 1'b1;
                        state_r <= S_GAP_HI;
                    end
                end
                S_GAP_HI: state_r <= S_LO;
                S_LO: begin
                    if (tx_ready) begin
                        tx_data <= word_r[7:0];
                        wr      <= 1'b1;
                        state_r <= S_GAP_LO;
                    end
                end
                S_GAP_LO: begin
                    if (word_r == TERM_WORD) begin
                        hazard <= 1'b1;
                    end
                    addr_r      <= addr_r + ADDR_W'(2);
                    remaining_r <= remaining_r - 16'd1;
                    // Tested before the decrement lands, so 16'hffff words never underflow.
                    if (remaining_r != 16'd1) begin
                        state_r <= S_RD;
                    end else if (term_en_r) begin
                        state_r <= S_TERM_HI;
                    end else begin
                        state_r <= S_FIN;
                    end
                end
                S_TERM_HI: begin
                    if (tx_ready) begin
                        tx_data <= TERM_WORD[15:8];
                        wr      <= 1'b1;
                        state_r <= S_TERM_GAP_HI;
                    end
                end
                S_TERM_GAP_HI: state_r <= S_TERM_LO;
                S_TERM_LO: begin
                    if (tx_ready) begin
                        tx_data <= TERM_WORD[7:0];
                        wr      <= 1'b1;
                        state_r <= S_TERM_GAP_LO;
                    end
                end
                S_TERM_GAP_LO: state_r <= S_FIN;
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_sender.sv
// Directed bench: stimulus pushes expected bytes/read addresses into queues,
// a negedge monitor pops and compares whenever wr or rd_mem fires.
module tb_uart_word_sender;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [15:0]   word_count;
    logic          send_term;
    logic          busy, done, rd_mem, wr, hazard;
    logic [AW-1:0] mem_addr;
    logic [15:0]   rd_data;
    logic [7:0]    tx_data;
    logic          tx_ready;

    uart_word_sender #(.ADDR_W(AW), .TERM_WORD(16'h7fff)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_count(word_count), .send_term(send_term), .busy(busy),
        .done(done), .mem_addr(mem_addr), .rd_mem(rd_mem), .rd_data(rd_data),
        .tx_data(tx_data), .wr(wr), .tx_ready(tx_ready), .hazard(hazard)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:511];
    always @(posedge clk) if (rd_mem) rd_data <= mem[mem_addr[AW-1:1]];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_rd = -1;
    int first_wr = -1;
    int s_cyc = 0;
    logic rdy_seen;
    logic wr_prev = 1'b0;
    logic rnd_en = 1'b0;
    logic [7:0]    exp_bytes [$];
    logic [AW-1:0] exp_addrs [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rdy_seen <= tx_ready;
    end

    always @(negedge clk) if (rnd_en) tx_ready = 1'($urandom_range(0, 1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe the DUT presents is checked here.
    always @(negedge clk) begin
        if (wr) begin
            check("wr_while_not_ready", {31'd0, rdy_seen}, 32'd1);
            check("wr_back_to_back", {31'd0, wr_prev}, 32'd0);
            if (exp_bytes.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_wr: got byte %0h expected none", tx_data);
            end else begin
                check("tx_byte", {24'd0, tx_data}, {24'd0, exp_bytes.pop_front()});
            end
            if (first_wr < 0) first_wr = cyc;
        end
        wr_prev = wr;
        if (rd_mem) begin
            if (exp_addrs.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_rd: got addr %0h expected none", mem_addr);
            end else begin
                check("rd_addr", {22'd0, mem_addr}, {22'd0, exp_addrs.pop_front()});
            end
            if (first_rd < 0) first_rd = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic do_start(input logic [AW-1:0] a, input logic [15:0] n, input logic t);
        @(negedge clk);
        start_addr = a; word_count = n; send_term = t; start = 1'b1;
        first_rd = -1; first_wr = -1; s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
        end
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, target);
        check("bytes_left", exp_bytes.size(), 0);
        check("reads_left", exp_addrs.size(), 0);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic push_bytes(input logic [47:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bytes.push_back(b[i*8 +: 8]);
    endtask

    initial begin
        int base;
        int t;
        rst = 1'b0; start = 1'b0; start_addr = '0; word_count = 16'd0;
        send_term = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 3);
        mem[9'h180] = 16'h1234;
        mem[9'h181] = 16'habcd;
        mem[9'h1ff] = 16'h0102;
        mem[9'h000] = 16'h0304;
        repeat (3) @(negedge clk);
        check("reset_outputs", {17'd0, busy, done, rd_mem, wr, hazard, mem_addr, tx_data}, 32'd0);
        rst = 1'b1;

        // Basic two-word transfer with terminator, plus an ignored start while busy.
        base = done_cnt;
        push_bytes(48'h1234abcd7fff, 6);
        exp_addrs.push_back(10'h300); exp_addrs.push_back(10'h302);
        do_start(10'h300, 16'd2, 1'b1);
        repeat (5) @(negedge clk);
        check("rd_latency", first_rd, s_cyc + 2);
        check("wr_latency", first_wr, s_cyc + 4);
        check("busy_during", {31'd0, busy}, 32'd1);
        start_addr = 10'h000; word_count = 16'd5; send_term = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(base + 1);
        check("hazard_clean", {31'd0, hazard}, 32'd0);

        // Terminator only.
        base = done_cnt;
        push_bytes(48'h7fff, 2);
        do_start(10'h300, 16'd0, 1'b1);
        wait_done(base + 1);

        // Empty transfer: done two cycles after start; start during done dropped.
        base = done_cnt;
        do_start(10'h300, 16'd0, 1'b0);
        @(negedge clk);
        check("done_latency", {31'd0, done}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_on_done_ignored", {31'd0, busy}, 32'd0);
        wait_done(base + 1);

        // Pseudo-random tx_ready back-pressure.
        base = done_cnt;
        push_bytes(48'h1234abcd7fff, 6);
        exp_addrs.push_back(10'h300); exp_addrs.push_back(10'h302);
        rnd_en = 1'b1;
        do_start(10'h300, 16'd2, 1'b1);
        wait_done(base + 1);
        rnd_en = 1'b0;
        @(negedge clk);
        tx_ready = 1'b1;

        // Address wrap, then odd start address.
        base = done_cnt;
        push_bytes(48'h01020304, 4);
        exp_addrs.push_back(10'h3fe); exp_addrs.push_back(10'h000);
        do_start(10'h3fe, 16'd2, 1'b0);
        wait_done(base + 1);
        base = done_cnt;
        push_bytes(48'h1234, 2);
        exp_addrs.push_back(10'h300);
        do_start(10'h301, 16'd1, 1'b0);
        wait_done(base + 1);

        // Data word equal to the terminator raises hazard.
        mem[9'h180] = 16'h7fff;
        base = done_cnt;
        push_bytes(48'h7fff7fff, 4);
        exp_addrs.push_back(10'h300);
        do_start(10'h300, 16'd1, 1'b1);
        wait_done(base + 1);
        check("hazard_set", {31'd0, hazard}, 32'd1);
        mem[9'h180] = 16'h1234;

        // Reset while stalled in the low byte aborts without a done pulse.
        base = done_cnt;
        push_bytes(48'h12, 1);
        exp_addrs.push_back(10'h300);
        do_start(10'h300, 16'd2, 1'b1);
        check("hazard_cleared", {31'd0, hazard}, 32'd0);
        t = 0;
        while (first_wr < 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("first_byte_seen", {31'd0, first_wr >= 0}, 32'd1);
        tx_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("stall_no_wr", {31'd0, wr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_outputs", {17'd0, busy, done, rd_mem, wr, hazard, mem_addr, tx_data}, 32'd0);
        tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt, base);
        check("abort_bytes", exp_bytes.size(), 0);

        // New start accepted after reset release.
        push_bytes(48'h7fff, 2);
        do_start(10'h300, 16'd0, 1'b1);
        wait_done(base + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_word_sender.md
Name: uart_word_sender

Overview:
- Transmit-side counterpart of the MCU's UART program loader.
- Reads a block of 16-bit words from memory and emits each word as two UART bytes, upper byte first.
- Optionally appends the loader terminator 16'h7fff, so a second board running the loader can be programmed directly from this board's memory.
- Sits between the memory bus arbiter and the byte-level uart transmitter (tx_data/wr/tx_ready handshake).

Parameters:
- ADDR_W, 10: memory address width; the MCU instance ties it to `ADDR_WIDTH.
- TERM_WORD, 16'h7fff: terminator word sent after the data when send_term=1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-low (0 = reset, sampled on posedge clk)
- start  in  1  one-cycle request to begin a transfer; ignored while busy=1
- start_addr  in  ADDR_W  byte address of first word, sampled on start; bit 0 forced to 0
- word_count  in  16  number of data words, sampled on start; 0 = no data words
- send_term  in  1  sampled on start; 1 = append TERM_WORD after the data
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the transfer is finished
- mem_addr  out  ADDR_W  memory read address (registered)
- rd_mem  out  1  one-cycle read strobe; memory returns rd_data one cycle later
- rd_data  in  16  memory read data
- tx_data  out  8  byte presented to the uart transmitter
- wr  out  1  one-cycle byte write strobe to the uart transmitter
- tx_ready  in  1  uart transmitter can accept a byte
- hazard  out  1  sticky: a data word equal to TERM_WORD was sent

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, busy=0, done=0, rd_mem=0, wr=0, mem_addr=0, tx_data=0, hazard=0, internal counters=0.
- A reset asserted mid-transfer aborts it at that edge. No further wr or rd_mem is issued, and no done pulse is produced.
- Only rd_mem, wr and done are pulses. Every other output holds its value until changed.
- IDLE:
  - On start=1: latch start_addr&~1 into addr, word_count into remaining, send_term into term_en; clear hazard; busy<=1.
  - If word_count!=0, go to RD. Else go to TERM_HI if term_en, otherwise FIN.
- RD: mem_addr<=addr, rd_mem<=1 for one cycle; go to CAP.
- CAP: capture rd_data into word register. rd_data is valid in the cycle after rd_mem. Go to HI.
- HI:
  - Wait until tx_ready=1, then tx_data<=word[15:8], wr<=1 for one cycle; go to GAP_HI.
  - Never assert wr in a cycle where tx_ready was 0.
- GAP_HI: one idle cycle so tx_ready can deassert; go to LO.
- LO: as HI with word[7:0]; then go to GAP_LO.
- GAP_LO:
  - If word==TERM_WORD and the word is data, hazard<=1.
  - addr<=addr+2 (wraps modulo 2^ADDR_W); remaining<=remaining-1.
  - If remaining-1!=0, go to RD. Else go to TERM_HI if term_en, otherwise FIN.
- TERM_HI / TERM_LO: send TERM_WORD[15:8] then TERM_WORD[7:0] under the same tx_ready/wr rules, each followed by one gap cycle.
  - No memory access.
  - The terminator never sets hazard.
- FIN: done<=1 for one cycle, busy<=0, return to IDLE.
- Latency: with tx_ready=1 held, start at cycle 0 gives rd_mem at cycle 2 and first wr at cycle 4. A word costs 6 cycles minimum, excluding tx_ready stalls.
- Simultaneous events:
  - start while busy is ignored, and latched parameters do not change.
  - start in the same cycle as done is ignored; a new start is accepted from the next cycle.
- tx_ready low indefinitely: the block waits in HI/LO/TERM_*, holding tx_data stable and wr=0.
- word_count=16'hffff is legal. The 16-bit remaining counter never underflows because it is tested before decrement.

Test Plan:
- Memory 0x300=16'h1234, 0x302=16'hABCD; start_addr=0x300, word_count=2, send_term=1, tx_ready=1 -> wr bytes 12,34,AB,CD,7F,FF in order; rd_mem at 0x300 and 0x302 only; single done pulse; hazard=0.
- word_count=0, send_term=1 -> no rd_mem, bytes 7F,FF, then done. Same with send_term=0 -> no wr, done 2 cycles after start.
- tx_ready toggled pseudo-randomly -> no wr while tx_ready=0, at least one cycle between wr pulses, byte order unchanged; a loopback into the loader writes 0x300/0x302 identically.
- start_addr=10'h3fe, word_count=2 -> reads 0x3fe then 0x000 (wrap); start_addr=0x301 -> first read at 0x300.
- Data word 16'h7fff at 0x300, word_count=1, send_term=1 -> hazard=1 after its low byte, terminator still sent; hazard cleared by the next start.
- rst=0 asserted while in LO with tx_ready=0, held 1 cycle -> all outputs zero next edge, no done; second start during busy ignored; start accepted after reset release.
